tlp_tx_arbiter: RTL and testbench

Parametrised FPGA->Host TLP merger: packet-atomically arbitrates `NUM_CHANS` independent TLP producer streams onto the single `txData/txSOP/txEOP/txValid/txReady` pipe of `pcie_sv`. It sits between multiple application engines (e.g. completer plus DMA writer) and the PCIe core in the `pcieClk` domain. It generalises the one-producer wiring to N channels with selectable round-robin or fixed-priority arbitration. It adds a one-beat registered output stage for timing.

---
 rtl/tlp_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_tlp_tx_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tlp_tx_arbiter.sv
// rtl/tlp_tx_arbiter.sv - packet-atomic N:1 TLP merger with one-beat output register; TLP_ARB_PKTCOUNT_EN builds per-channel packet counters
module tlp_tx_arbiter #(
  parameter int NUM_CHANS  = 2,
  parameter int DATA_WIDTH = 64,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                            pcieClk_in,
  input  logic                            reset_in,
  input  logic [NUM_CHANS*DATA_WIDTH-1:0] chData_in,
  input  logic [NUM_CHANS-1:0]            chSOP_in,
  input  logic [NUM_CHANS-1:0]            chEOP_in,
  input  logic [NUM_CHANS-1:0]            chValid_in,
  output logic [NUM_CHANS-1:0]            chReady_out,
  output logic [DATA_WIDTH-1:0]           txData_out,
  output logic                            txSOP_out,
  output logic                            txEOP_out,
  output logic                            txValid_out,
  input  logic                            txReady_in,
  output logic [$clog2(NUM_CHANS)-1:0]    grant_out,
  output logic [NUM_CHANS*32-1:0]         pktCount_out
);

  localparam int IW = $clog2(NUM_CHANS);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  state_e                 state_q;
  logic [IW-1:0]          owner_q;
  logic [IW-1:0]          last_grant_q;
  logic [IW-1:0]          grant_q;
  logic [DATA_WIDTH-1:0]  tx_data_q;
  logic                   tx_sop_q;
  logic                   tx_eop_q;
  logic                   tx_valid_q;

  logic                   free;
  logic                   any_valid;
  logic [IW-1:0]          winner;
  logic [IW-1:0]          sel;
  logic                   accept;
  logic                   acc_eop;

  // Output register can take a new beat when empty or being drained this cycle
  assign free      = !tx_valid_q || txReady_in;
  assign any_valid = |chValid_in;
  assign sel       = (state_q == LOCKED) ? owner_q : winner;
  assign accept    = chValid_in[sel] && chReady_out[sel];
  assign acc_eop   = chEOP_in[sel];

  // Winner among valid channels: lowest index, or rotating from the channel after the last grant
  always_comb begin
    int j;
    winner = '0;
    j      = 0;
    if (FIXED_PRIO) begin
      for (int i = NUM_CHANS - 1; i >= 0; i--) begin
        if (chValid_in[IW'(i)]) winner = IW'(i);
      end
    end else begin
      // Scan from farthest to nearest so the nearest valid channel is the last assignment
      for (int k = NUM_CHANS; k >= 1; k--) begin
        j = (int'(last_grant_q) + k) % NUM_CHANS;
        if (chValid_in[IW'(j)]) winner = IW'(j);
      end
    end
  end

  // One-hot ready toward the owner (locked) or the winner (unlocked); held low during reset
  always_comb begin
    chReady_out = '0;
    if (!reset_in && free && (state_q == LOCKED || any_valid)) begin
      chReady_out[sel] = 1'b1;
    end
  end

  // Packet lock FSM: a multi-beat TLP holds the pipe until its EOP beat is accepted
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= UNLOCKED;
      owner_q      <= '0;
      last_grant_q <= IW'(NUM_CHANS - 1);
      grant_q      <= '0;
    end else if (accept) begin
      if (state_q == UNLOCKED) begin
        last_grant_q <= winner;
        grant_q      <= winner;
        if (!acc_eop) begin
          state_q <= LOCKED;
          owner_q <= winner;
        end
      end else if (acc_eop) begin
        state_q <= UNLOCKED;
      end
    end
  end

  // Output stage: load on acceptance, drop the beat once drained, hold under backpressure
  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      tx_data_q  <= '0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_valid_q <= 1'b0;
    end else if (accept) begin
      tx_data_q  <= chData_in[sel*DATA_WIDTH +: DATA_WIDTH];
      tx_sop_q   <= chSOP_in[sel];
      tx_eop_q   <= acc_eop;
      tx_valid_q <= 1'b1;
    end else if (txReady_in) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign txData_out  = tx_data_q;
  assign txSOP_out   = tx_sop_q;
  assign txEOP_out   = tx_eop_q;
  assign txValid_out = tx_valid_q;
  assign grant_out   = grant_q;

`ifdef TLP_ARB_PKTCOUNT_EN
  for (genvar g = 0; g < NUM_CHANS; g++) begin : g_cnt
    logic [31:0] cnt_q;

    // Count completed TLPs per channel; wraps naturally at 32 bits
    always_ff @(posedge pcieClk_in or posedge reset_in) begin
      if (reset_in) begin
        cnt_q <= '0;
      end else if (accept && acc_eop && (sel == IW'(g))) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end

    assign pktCount_out[g*32 +: 32] = cnt_q;
  end
`else
  assign pktCount_out = '0;
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb/tb_tlp_tx_arbiter.sv - randomized self-checking bench for tlp_tx_arbiter against a packet-level reference model
module tb_tlp_tx_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
);

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              reset_in;
  logic [N*DW-1:0]   chData_in;
  logic [N-1:0]      chSOP_in, chEOP_in, chValid_in, chReady_out;
  logic [DW-1:0]     txData_out;
  logic              txSOP_out, txEOP_out, txValid_out, txReady_in;
  logic [IW-1:0]     grant_out;
  logic [N*32-1:0]   pktCount_out;

  always #5 clk = ~clk;

  tlp_tx_arbiter #(.NUM_CHANS(N), .DATA_WIDTH(DW), .FIXED_PRIO(FIXED_PRIO)) dut (
    .pcieClk_in  (clk),
    .reset_in    (reset_in),
    .chData_in   (chData_in),
    .chSOP_in    (chSOP_in),
    .chEOP_in    (chEOP_in),
    .chValid_in  (chValid_in),
    .chReady_out (chReady_out),
    .txData_out  (txData_out),
    .txSOP_out   (txSOP_out),
    .txEOP_out   (txEOP_out),
    .txValid_out (txValid_out),
    .txReady_in  (txReady_in),
    .grant_out   (grant_out),
    .pktCount_out(pktCount_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // producer state per channel
  int p_seq[N], p_beat[N], p_len[N];
  // consumer-side ordering trackers
  int out_seq[N], out_beat[N];
  bit out_mid;
  int out_ch;
  // reference model
  bit          m_locked;
  int          m_owner, m_last, m_grant;
  bit          m_txv, m_sop, m_eop;
  logic [63:0] m_txd;
  logic [31:0] m_cnt[N];

  function automatic logic [63:0] beat_word(input int c, input int s, input int b);
    return {8'(c), 16'(s), 8'(b), 32'(s * 7 + b * 13 + c * 101)};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_last = N - 1; m_grant = 0;
    m_txv = 0; m_sop = 0; m_eop = 0; m_txd = '0;
    out_mid = 0; out_ch = 0;
    for (int c = 0; c < N; c++) begin
      m_cnt[c]    = '0;
      p_seq[c]    = p_seq[c] + 1;
      p_beat[c]   = 0;
      p_len[c]    = $urandom_range(1, 4);
      out_seq[c]  = p_seq[c];
      out_beat[c] = 0;
    end
  endtask

  task automatic step(input int pv, input int pr);
    logic [N-1:0] exp_rdy, acc;
    int sel, c, s, b;
    bit free;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chValid_in[i]         = (int'($urandom_range(99)) < pv);
      chData_in[i*DW +: DW] = beat_word(i, p_seq[i], p_beat[i]);
      chSOP_in[i]           = (p_beat[i] == 0);
      chEOP_in[i]           = (p_beat[i] == p_len[i] - 1);
    end
    txReady_in = (int'($urandom_range(99)) < pr);
    #1;
    // expected ready from the arbitration rules
    free    = !m_txv || txReady_in;
    exp_rdy = '0;
    sel     = -1;
    if (m_locked) sel = m_owner;
    else if (FIXED_PRIO) begin
      for (int i = N - 1; i >= 0; i--) if (chValid_in[i]) sel = i;
    end else begin
      for (int k = N; k >= 1; k--) if (chValid_in[(m_last + k) % N]) sel = (m_last + k) % N;
    end
    if (free && sel >= 0) exp_rdy[sel] = 1'b1;
    chk("ready", 64'(chReady_out), 64'(exp_rdy));
    // consumer: each channel's beats arrive in order, packets never interleave
    if (txValid_out && txReady_in) begin
      c = int'(txData_out[63:56]);
      s = int'(txData_out[55:40]);
      b = int'(txData_out[39:32]);
      if (c >= N) chk("chan_range", 64'(c), 64'(N - 1));
      else begin
        if (out_mid) chk("no_interleave", 64'(c), 64'(out_ch));
        chk("beat_order", {32'(s), 32'(b)}, {32'(out_seq[c] & 16'hffff), 32'(out_beat[c])});
        if (txEOP_out) begin out_seq[c]++; out_beat[c] = 0; out_mid = 0; end
        else begin out_beat[c]++; out_mid = 1; out_ch = c; end
      end
    end
    acc = exp_rdy & chValid_in;
    @(posedge clk);
    #1;
    if (acc != '0) begin
      c = 0;
      for (int i = 0; i < N; i++) if (acc[i]) c = i;
      m_txv = 1;
      m_txd = beat_word(c, p_seq[c], p_beat[c]);
      m_sop = (p_beat[c] == 0);
      m_eop = (p_beat[c] == p_len[c] - 1);
      if (!m_locked) begin
        m_last = c; m_grant = c;
        if (!m_eop) begin m_locked = 1; m_owner = c; end
      end else if (m_eop) m_locked = 0;
      if (m_eop) begin
        m_cnt[c]++; p_seq[c]++; p_beat[c] = 0; p_len[c] = $urandom_range(1, 4);
      end else p_beat[c]++;
    end else if (txReady_in) m_txv = 0;
    chk("txValid", 64'(txValid_out), 64'(m_txv));
    if (m_txv) begin
      chk("txData", txData_out, m_txd);
      chk("txSOP", 64'(txSOP_out), 64'(m_sop));
      chk("txEOP", 64'(txEOP_out), 64'(m_eop));
    end
    chk("grant", 64'(grant_out), 64'(m_grant));
    for (int i = 0; i < N; i++) begin
`ifdef TLP_ARB_PKTCOUNT_EN
      chk("pktCount", 64'(pktCount_out[i*32 +: 32]), 64'(m_cnt[i]));
`else
      chk("pktCount", 64'(pktCount_out[i*32 +: 32]), 64'd0);
`endif
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_txValid"}, 64'(txValid_out), 64'd0);
    chk({tag, "_chReady"}, 64'(chReady_out), 64'd0);
    chk({tag, "_txData"},  txData_out, 64'd0);
    chk({tag, "_sopeop"},  64'({txSOP_out, txEOP_out}), 64'd0);
    chk({tag, "_grant"},   64'(grant_out), 64'd0);
    chk({tag, "_pktCount"}, 64'(pktCount_out), 64'd0);
  endtask

  int ph_cyc[7] = '{150, 120, 5, 150, 150, 100, 150};
  int ph_pv [7] = '{ 60, 100, 100, 30, 100, 80, 50};
  int ph_pr [7] = '{ 80, 100,   0, 40,  50, 100, 70};

  initial begin
    for (int c = 0; c < N; c++) p_seq[c] = 0;
    reset_in   = 1'b1;
    chValid_in = '1;
    chSOP_in   = '1;
    chEOP_in   = '0;
    chData_in  = '1;
    txReady_in = 1'b1;
    model_reset();
    #12;
    check_reset_outputs("rst0");
    @(negedge clk);
    chValid_in = '0;
    reset_in   = 1'b0;

    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < ph_cyc[p]; k++) step(ph_pv[p], ph_pr[p]);
    end

    // reset in the middle of a locked multi-beat packet
    for (int k = 0; k < 60 && !(m_locked && m_txv); k++) step(100, 100);
    chk("lock_reached", 64'(m_locked), 64'd1);
    #2;
    reset_in = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_reset();
    @(negedge clk);
    chValid_in = '0;
    @(negedge clk);
    reset_in = 1'b0;
    step(100, 100);
    chk("post_rst_grant", 64'(grant_out), 64'd0);

    for (int k = 0; k < 200; k++) step(70, 75);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
